alu_seq: RTL and testbench

Multi-cycle sequencer that sits between the control path and the 8-bit combinational ALU. It runs one NBYTES-wide operation as NBYTES consecutive byte operations over the ALU's command/operand interface. It chains the ALU's shift/carry out back into shift/carry in, collects the result bytes, and reports the wide result with carry, zero and parity flags. It is the driving end of the ALU interface: it produces alu_cmd/inA/inB/sc_i and consumes rslt/sc_o.

---
 rtl/alu_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle sequencer that runs an NBYTES-wide operation as a chain of byte
// operations on an external 8-bit ALU, chaining shift/carry between bytes.
module alu_seq #(
    parameter int unsigned NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic [8*NBYTES-1:0]   opA,
    input  logic [8*NBYTES-1:0]   opB,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  zero_o,
    output logic                  pari_o,
    output logic                  err,
    output logic [3:0]            alu_cmd,
    output logic [7:0]            alu_inA,
    output logic [7:0]            alu_inB,
    output logic                  alu_sc_i,
    input  logic [7:0]            alu_rslt,
    input  logic                  alu_sc_o
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic            cin_q, cin_d;
    logic [IW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d, zero_q, zero_d, pari_q, pari_d;
    logic            err_q, err_d, busy_q, busy_d, done_q, done_d;

    logic            msb_first, first, chain_in;
    int unsigned     bsel;
    logic [7:0]      a_byte, b_byte;

    // ALU drive: byte order depends on shift direction, carry chains from k=0 seed
    always_comb begin
        msb_first = (op_q == 4'd3) || (op_q == 4'd4);
        bsel      = msb_first ? (NBYTES - 1 - 32'(k_q)) : 32'(k_q);
        first     = (k_q == '0);
        a_byte    = a_q[8*bsel +: 8];
        b_byte    = b_q[8*bsel +: 8];
        chain_in  = first ? cin_q : carry_q;
        alu_cmd   = 4'd8;
        alu_inA   = 8'h00;
        alu_inB   = 8'h00;
        alu_sc_i  = 1'b0;
        if (state_q == StRun) begin
            alu_inA = a_byte;
            alu_inB = b_byte;
            case (op_q)
                4'd0: begin alu_cmd = 4'd0; alu_sc_i = chain_in; end
                4'd1: begin
                    alu_cmd  = 4'd0;
                    alu_inB  = ~b_byte;
                    alu_sc_i = first ? 1'b1 : carry_q;
                end
                4'd2: begin alu_cmd = 4'd2; alu_sc_i = chain_in; end
                4'd3: begin
                    alu_cmd  = first ? 4'd3 : 4'd4;
                    alu_sc_i = first ? 1'b0 : carry_q;
                end
                4'd4: begin alu_cmd = 4'd4; alu_sc_i = chain_in; end
                4'd5: begin alu_cmd = 4'd7; alu_inB = 8'hFF; end
                4'd6: alu_cmd = 4'd6;
                4'd7: alu_cmd = 4'd7;
                default: alu_cmd = 4'd8;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        k_d      = k_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        pari_d   = pari_q;
        err_d    = err_q;
        case (state_q)
            StRun: begin
                acc_d[8*bsel +: 8] = alu_rslt;
                carry_d = (op_q <= 4'd4) ? alu_sc_o : 1'b0;
                if (k_q == IW'(NBYTES - 1)) begin
                    state_d  = StDone;
                    k_d      = '0;
                    result_d = acc_d;
                    cout_d   = carry_d;
                    zero_d   = (acc_d == '0);
                    pari_d   = ^acc_d;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            default: begin
                if (state_q == StDone) state_d = StIdle;
                if (start) begin
                    // Illegal ops are folded into pass A at latch time
                    op_d    = (op > 4'd8) ? 4'd8 : op;
                    err_d   = (op > 4'd8);
                    a_d     = opA;
                    b_d     = opB;
                    cin_d   = cin;
                    k_d     = '0;
                    carry_d = 1'b0;
                    state_d = StRun;
                end
            end
        endcase
        busy_d = (state_d == StRun);
        // Completion is flagged the cycle after the DONE state is reached
        done_d = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= 4'd0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            k_q      <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
            pari_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            pari_q   <= pari_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign zero_o = zero_q;
    assign pari_o = pari_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (NBYTES=2) with a behavioural 8-bit ALU attached to its
// ALU port and a scoreboard of expected wide results.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n, start, cin;
    logic [3:0]  op;
    logic [15:0] opA, opB;
    logic        busy, done, cout, zero_o, pari_o, err;
    logic [15:0] result;
    logic [3:0]  alu_cmd;
    logic [7:0]  alu_inA, alu_inB, alu_rslt;
    logic        alu_sc_i, alu_sc_o;

    always #5 clk = ~clk;

    alu_seq #(.NBYTES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(opA), .opB(opB),
        .cin(cin), .busy(busy), .done(done), .result(result), .cout(cout),
        .zero_o(zero_o), .pari_o(pari_o), .err(err), .alu_cmd(alu_cmd),
        .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_sc_i(alu_sc_i),
        .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o)
    );

    // Peer ALU model
    always_comb begin
        alu_rslt = alu_inA;
        alu_sc_o = 1'b0;
        case (alu_cmd)
            4'd0: {alu_sc_o, alu_rslt} = {1'b0, alu_inA} + {1'b0, alu_inB} + {8'd0, alu_sc_i};
            4'd2: begin alu_rslt = {alu_inA[6:0], alu_sc_i}; alu_sc_o = alu_inA[7]; end
            4'd3: begin alu_rslt = {alu_inA[7], alu_inA[7:1]}; alu_sc_o = alu_inA[0]; end
            4'd4: begin alu_rslt = {alu_sc_i, alu_inA[7:1]}; alu_sc_o = alu_inA[0]; end
            4'd6: alu_rslt = alu_inA & alu_inB;
            4'd7: alu_rslt = alu_inA ^ alu_inB;
            default: alu_rslt = alu_inA;
        endcase
    end

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        er;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] res;
        logic        co;
        logic        er;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   n_pass = 0;
    int   n_chk  = 0;
    logic [3:0] cmd0, cmd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: every done pulse pops and checks one expected result
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("cout",   32'(cout),   32'(e.co));
                chk("zero_o", 32'(zero_o), 32'(e.res == 16'h0000));
                chk("pari_o", 32'(pari_o), 32'(^e.res));
                chk("err",    32'(err),    32'(e.er));
            end
        end
    end

    task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] er, input logic eco,
                          input logic eer, input bit glitch);
        int lat;
        int busy_cnt;
        op = o; opA = a; opB = b; cin = c; start = 1'b1;
        sb.push_back('{er, eco, eer});
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        cmd0 = alu_cmd;
        if (glitch) begin
            op = 4'd1; opA = 16'hFFFF; opB = 16'hFFFF; start = 1'b1;
        end
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (i == 1) cmd1 = alu_cmd;
            if (busy) busy_cnt++;
            if (done) begin lat = i; break; end
        end
        chk("latency", 32'(lat), 32'd3);
        chk("busy_cycles", 32'(busy_cnt), 32'd2);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 4'd0; opA = 16'h0; opB = 16'h0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   32'(busy),    32'd0);
        chk("rst_done",   32'(done),    32'd0);
        chk("rst_result", 32'(result),  32'd0);
        chk("rst_cout",   32'(cout),    32'd0);
        chk("rst_zero",   32'(zero_o),  32'd1);
        chk("rst_pari",   32'(pari_o),  32'd0);
        chk("rst_err",    32'(err),     32'd0);
        chk("rst_cmd",    32'(alu_cmd), 32'd8);
        rst_n = 1'b1;

        vecs[0]  = '{4'd0,  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{4'd1,  16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0};
        vecs[2]  = '{4'd1,  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[3]  = '{4'd2,  16'h8000, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[4]  = '{4'd3,  16'h8001, 16'h0000, 1'b1, 16'hC000, 1'b1, 1'b0};
        vecs[5]  = '{4'd4,  16'h0001, 16'h0000, 1'b1, 16'h8000, 1'b1, 1'b0};
        vecs[6]  = '{4'd5,  16'h00F0, 16'h1234, 1'b0, 16'hFF0F, 1'b0, 1'b0};
        vecs[7]  = '{4'd6,  16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 1'b0, 1'b0};
        vecs[8]  = '{4'd7,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{4'd12, 16'hA5C3, 16'h1234, 1'b1, 16'hA5C3, 1'b0, 1'b1};
        vecs[10] = '{4'd0,  16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0, 1'b0};
        vecs[11] = '{4'd0,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].res, vecs[i].co,
                   vecs[i].er, 1'b0);
            if (vecs[i].op == 4'd3) begin
                chk("asr_cmd_k0", 32'(cmd0), 32'd3);
                chk("asr_cmd_k1", 32'(cmd1), 32'd4);
            end
        end
        chk("idle_cmd", 32'(alu_cmd), 32'd8);

        // start pulsed mid-RUN with other operands must be ignored
        run_op(4'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);

        // start held high through DONE: second op accepted back-to-back
        op = 4'd6; opA = 16'hF0F0; opB = 16'h0FF0; cin = 1'b0; start = 1'b1;
        sb.push_back('{16'h00F0, 1'b0, 1'b0});
        @(posedge clk); #1;
        op = 4'd7; opA = 16'hFFFF; opB = 16'h00FF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sb.push_back('{16'hFF00, 1'b0, 1'b0});
        @(posedge clk); #1;
        chk("b2b_done1", 32'(done), 32'd1);
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk("b2b_done2", 32'(done), (i == 3) ? 32'd1 : 32'd0);
        end

        // reset during RUN aborts the operation
        op = 4'd0; opA = 16'h1234; opB = 16'h1111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_zero",   32'(zero_o), 32'd1);
        chk("abort_cout",   32'(cout),   32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done), 32'd0);
        end
        run_op(4'd0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
